bldc_fg_emu: RTL and testbench

Synthesizable BLDC motor/tachometer emulator that closes the loop opposite the fractional-PWM controller. It consumes the controller's PWM drive, turns duty into a first-order-lagged speed, and emits an FG (frequency-generator) tach square wave suitable for the controller's FG input. This replaces the bench's open-loop fixed-frequency FG toggle so closed-loop lock can be exercised in simulation and on the board.

---
 rtl/bldc_fg_emu_if.sv | 16 +
 rtl/bldc_fg_emu.sv | 68 ++++++
 tb/tb_bldc_fg_emu.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/bldc_fg_emu_if.sv
`timescale 1ns/1ps
// bldc_fg_emu_if: PWM drive and enable in, tach and speed telemetry out
interface bldc_fg_emu_if #(
   parameter int WIN_LOG2 = 10,
   parameter int NCO_W    = 32
);
   logic                PWM;
   logic                EN;
   logic                FG;
   logic                FG_EDGE;
   logic [WIN_LOG2:0]   DUTY;
   logic                WIN_STB;
   logic [NCO_W-1:0]    SPEED;
   modport master (output PWM, EN, input FG, FG_EDGE, DUTY, WIN_STB, SPEED);
   modport slave  (input PWM, EN, output FG, FG_EDGE, DUTY, WIN_STB, SPEED);
endinterface

// File: rtl/bldc_fg_emu.sv
`timescale 1ns/1ps
// bldc_fg_emu: BLDC motor emulator turning PWM duty into a first-order-lagged speed and an FG tach wave
module bldc_fg_emu #(
   parameter int WIN_LOG2   = 10,
   parameter int K_SHIFT    = 4,
   parameter int GAIN_SHIFT = 4,
   parameter int NCO_W      = 32
) (
   input logic           CLK1,
   input logic           RESET_N,
   bldc_fg_emu_if.slave  bus
);
   localparam int SW = NCO_W + 2;
   logic                     pwm_m, pwm_s;
   logic [WIN_LOG2-1:0]      wcnt;
   logic [WIN_LOG2:0]        hcnt, duty;
   logic                     win_stb;
   logic [NCO_W-1:0]         speed, speed_nxt, phase;
   logic                     fg, fg_d;
   logic signed [NCO_W:0]    t, d, s0, s;
   logic signed [SW-1:0]     sum;
   // two-flop synchronizer for the asynchronous PWM input
   always_ff @(posedge CLK1 or negedge RESET_N)
      if (!RESET_N) {pwm_m, pwm_s} <= '0;
      else {pwm_m, pwm_s} <= {bus.PWM, pwm_m};
   // fixed-length duty window; the boundary cycle's sample is folded into DUTY
   always_ff @(posedge CLK1 or negedge RESET_N)
      if (!RESET_N) begin
         wcnt    <= '0;
         hcnt    <= '0;
         duty    <= '0;
         win_stb <= 1'b0;
      end else begin
         wcnt    <= wcnt + 1'b1;
         win_stb <= &wcnt;
         hcnt    <= &wcnt ? '0 : hcnt + (WIN_LOG2+1)'(pwm_s);
         if (&wcnt) duty <= hcnt + (WIN_LOG2+1)'(pwm_s);
      end
   // lag filter step toward target, with a +/-1 floor so SPEED lands exactly on target
   always_comb begin
      t         = bus.EN ? ({{(NCO_W-WIN_LOG2){1'b0}}, duty} << GAIN_SHIFT) : '0;
      d         = t - $signed({1'b0, speed});
      s0        = d >>> K_SHIFT;
      s         = (d != 0 && s0 == 0) ? (d[NCO_W] ? '1 : (NCO_W+1)'(1)) : s0;
      sum       = $signed({2'b00, speed}) + $signed({s[NCO_W], s});
      speed_nxt = sum[SW-1] ? '0 : sum[NCO_W] ? '1 : sum[NCO_W-1:0];
   end
   // speed only moves in the strobe cycle that follows each window
   always_ff @(posedge CLK1 or negedge RESET_N)
      if (!RESET_N) speed <= '0;
      else if (win_stb) speed <= speed_nxt;
   // NCO: phase MSB registered as FG, delayed copy for rising-edge detect
   always_ff @(posedge CLK1 or negedge RESET_N)
      if (!RESET_N) begin
         phase <= '0;
         fg    <= 1'b0;
         fg_d  <= 1'b0;
      end else begin
         phase <= phase + speed;
         fg    <= phase[NCO_W-1];
         fg_d  <= fg;
      end
   assign bus.FG      = fg;
   assign bus.FG_EDGE = fg & ~fg_d;
   assign bus.DUTY    = duty;
   assign bus.WIN_STB = win_stb;
   assign bus.SPEED   = speed;
endmodule

// File: tb/tb_bldc_fg_emu.sv
`timescale 1ns/1ps
// tb_bldc_fg_emu: scoreboard bench for the BLDC/FG emulator with a small window/speed reference model
module tb_bldc_fg_emu;
   localparam int WL  = 6;
   localparam int NW  = 16;
   localparam int WIN = 1 << WL;
   localparam int TOP = WIN * 16;
   logic    CLK1 = 1'b0;
   logic    RESET_N;
   int      checks = 0, failures = 0, mode = 0, cyc = 0;
   longint  dq[$], sq[$];
   bldc_fg_emu_if #(.WIN_LOG2(WL), .NCO_W(NW)) bus();
   bldc_fg_emu #(.WIN_LOG2(WL), .K_SHIFT(4), .GAIN_SHIFT(4), .NCO_W(NW)) dut (
      .CLK1(CLK1), .RESET_N(RESET_N), .bus(bus));
   always #5 CLK1 = ~CLK1;
   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask
   // PWM pattern: 0 = always high, 1 = 25% (1 high / 3 low), 2 = always low
   always @(negedge CLK1) begin
      cyc++;
      bus.PWM = (mode == 1) ? (cyc % 4 == 0) : (mode != 2);
   end
   // reference model: window/duty and speed filter, pushing expectations per window
   int  mw, mh, mduty;
   bit  mstb, p1, p2;
   longint msp;
   always @(posedge CLK1 or negedge RESET_N) begin
      if (!RESET_N) begin
         mw = 0; mh = 0; mduty = 0; mstb = 0; msp = 0; p1 = 0; p2 = 0;
         dq.delete(); sq.delete();
      end else begin
         if (mstb) begin
            longint t, d, s;
            t = bus.EN ? mduty * 16 : 0;
            d = t - msp;
            s = (d >= 0) ? d / 16 : -((-d + 15) / 16);
            if (d > 0 && s == 0) s = 1;
            msp += s;
            if (msp < 0) msp = 0;
            if (msp > 65535) msp = 65535;
         end
         mstb = 0;
         if (mw == WIN - 1) begin
            mduty = mh + int'(p2);
            mh = 0;
            mstb = 1;
            dq.push_back(mduty);
            sq.push_back(msp);
         end else mh += int'(p2);
         p2 = p1;
         p1 = bus.PWM;
         mw = (mw + 1) % WIN;
      end
   end
   // compare DUTY and the pre-update SPEED on every strobe
   always @(negedge CLK1)
      if (RESET_N === 1'b1 && bus.WIN_STB === 1'b1) begin
         if (dq.size() == 0) check("sb_empty", 0, 1);
         else begin
            check("duty", bus.DUTY, dq.pop_front());
            check("speed", bus.SPEED, sq.pop_front());
         end
         if (bus.SPEED > TOP) check("speed_max", bus.SPEED, TOP);
      end
   task automatic cycles(input int n);
      repeat (n) @(negedge CLK1);
   endtask
   task automatic reset_outs(input string tag);
      check({tag, "_fg"}, bus.FG, 0);
      check({tag, "_fg_edge"}, bus.FG_EDGE, 0);
      check({tag, "_duty"}, bus.DUTY, 0);
      check({tag, "_win_stb"}, bus.WIN_STB, 0);
      check({tag, "_speed"}, bus.SPEED, 0);
   endtask
   task automatic first_window();
      int n = 0;
      @(negedge CLK1);
      RESET_N = 1'b1;
      do begin
         @(posedge CLK1);
         #1;
         n++;
      end while (bus.WIN_STB !== 1'b1 && n < 2 * WIN);
      check("first_stb_cycle", n, WIN);
      check("first_duty", bus.DUTY, WIN - 2);
   endtask
   task automatic period(input string tag, input int exp);
      int n = 0;
      while (bus.FG_EDGE !== 1'b1 && n < 4 * exp) begin
         @(negedge CLK1);
         n++;
      end
      check({tag, "_edge_seen"}, bus.FG_EDGE, 1);
      n = 0;
      do begin
         @(negedge CLK1);
         n++;
      end while (bus.FG_EDGE !== 1'b1 && n < 4 * exp);
      check(tag, n, exp);
   endtask
   initial begin
      int edges, n;
      logic fg0;
      RESET_N = 1'b0;
      bus.EN  = 1'b1;
      mode    = 0;
      cycles(5);
      reset_outs("rst");
      first_window();
      cycles(150 * WIN);
      check("conv_full", bus.SPEED, TOP);
      period("fg_full", 65536 / TOP);
      mode = 1;
      cycles(150 * WIN);
      check("conv_quarter", bus.SPEED, TOP / 4);
      check("duty_quarter", bus.DUTY, WIN / 4);
      period("fg_quarter", 65536 / (TOP / 4));
      mode = 0;
      cycles(150 * WIN);
      check("reconv_full", bus.SPEED, TOP);
      bus.EN = 1'b0;
      cycles(160 * WIN);
      check("coast_speed", bus.SPEED, 0);
      check("coast_duty", bus.DUTY, WIN);
      edges = 0;
      fg0 = bus.FG;
      n = 0;
      repeat (1000) begin
         @(negedge CLK1);
         edges += int'(bus.FG_EDGE);
         n += int'(bus.FG != fg0);
      end
      check("coast_edges", edges, 0);
      check("coast_fg_frozen", n, 0);
      bus.EN = 1'b1;
      repeat (4) begin
         mode = 0;
         cycles(10 * WIN);
         mode = 2;
         cycles(10 * WIN);
      end
      mode = 0;
      n = 0;
      while (bus.SPEED < 500 && n < 100 * WIN) begin
         @(negedge CLK1);
         n++;
      end
      check("mid_speed_reached", bus.SPEED >= 500, 1);
      cycles(7);
      #2 RESET_N = 1'b0;
      #1 reset_outs("mid");
      cycles(3);
      first_window();
      cycles(20 * WIN);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
